// File: rtl/fractal_sync_join.sv
// fractal_sync_join: matches two child barrier requests, resolves locally or forwards upward, and merges parent responses into one registered response port.
module fractal_sync_join #(
  parameter int LVL_W   = 4,
  parameter int ID_W    = 4,
  parameter int DST_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  input  logic [LVL_W-1:0] req_level_i [2],
  input  logic [ID_W-1:0]  req_id_i [2],
  output logic [1:0]       req_ready_o,
  output logic             up_valid_o,
  output logic [LVL_W-1:0] up_level_o,
  output logic [ID_W-1:0]  up_id_o,
  input  logic             up_ready_i,
  input  logic             par_wake_i,
  input  logic [DST_W-1:0] par_dst_i,
  input  logic             par_error_i,
  output logic             rsp_wake_o,
  output logic [DST_W-1:0] rsp_dst_o,
  output logic             rsp_error_o
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, FWD, LOCAL} state_t;
  state_t state_q, state_d;
  logic [1:0] slot_v_q, slot_v_d, pend_clr_q, pend_clr_d, take, clr;
  logic [LVL_W-1:0] lvl_q [2];
  logic [ID_W-1:0] id_q [2];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DST_W-1:0] pend_dst_q, pend_dst_d, rsp_dst_q, rsp_dst_d;
  logic pend_err_q, pend_err_d, rsp_wake_q, rsp_wake_d, rsp_err_q, rsp_err_d;
  logic both, one, match, hit, go, emit;
  always_comb begin
    take = req_valid_i & ~slot_v_q;
    both = &slot_v_q;
    one = ^slot_v_q;
    match = lvl_q[0] == lvl_q[1] && id_q[0] == id_q[1] && lvl_q[0] != '0;
    // a request from the missing child arriving on the expiry cycle beats the timeout
    hit = TIMEOUT != 0 && state_q == IDLE && one && cnt_q == TMAX && take == 2'b00;
    go = state_q == IDLE && (both ? !(match && lvl_q[0] != LVL_W'(1)) : hit);
    pend_dst_d = go ? (both ? '1 : DST_W'(slot_v_q)) : pend_dst_q;
    pend_err_d = go ? !(both && match) : pend_err_q;
    pend_clr_d = go ? slot_v_q : pend_clr_q;
    emit = (go || state_q == LOCAL) && !par_wake_i;
    clr = emit ? pend_clr_d : (state_q == FWD && up_ready_i) ? 2'b11 : 2'b00;
    state_d = go ? (par_wake_i ? LOCAL : IDLE) :
              (state_q == IDLE && both) ? FWD :
              ((state_q == FWD && up_ready_i) || emit) ? IDLE : state_q;
    cnt_d = (state_q == IDLE && one && !hit) ? cnt_q + 1'b1 : '0;
    slot_v_d = (slot_v_q & ~clr) | take;
    rsp_wake_d = par_wake_i | emit;
    rsp_dst_d = par_wake_i ? par_dst_i : emit ? pend_dst_d : rsp_dst_q;
    rsp_err_d = par_wake_i ? par_error_i : emit ? pend_err_d : rsp_err_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      slot_v_q <= '0;
      cnt_q <= '0;
      pend_dst_q <= '0;
      pend_err_q <= 1'b0;
      pend_clr_q <= '0;
      rsp_wake_q <= 1'b0;
      rsp_dst_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_v_q <= slot_v_d;
      cnt_q <= cnt_d;
      pend_dst_q <= pend_dst_d;
      pend_err_q <= pend_err_d;
      pend_clr_q <= pend_clr_d;
      rsp_wake_q <= rsp_wake_d;
      rsp_dst_q <= rsp_dst_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (take[i]) begin
        lvl_q[i] <= req_level_i[i];
        id_q[i] <= req_id_i[i];
      end
    end
  end
  assign req_ready_o = ~slot_v_q;
  assign up_valid_o = state_q == FWD;
  assign up_level_o = lvl_q[0] - LVL_W'(1);
  assign up_id_o = id_q[0];
  assign rsp_wake_o = rsp_wake_q;
  assign rsp_dst_o = rsp_dst_q;
  assign rsp_error_o = rsp_err_q;
endmodule
